// File: rtl/vga_sprite_pkg.sv
// Shared timing defaults, attribute field widths and pipeline flag bundle
// for the VGA sprite compositor.
package vga_sprite_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned W_W   = 8;
    localparam int unsigned H_W   = 8;

    localparam int unsigned H_ACT_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned V_ACT_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;

    localparam logic [7:0] TRANSP_IDX_DEF = 8'hFF;
    localparam logic [7:0] BG_IDX_DEF     = 8'h00;

    function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic hit;
    } pix_flags_t;

    localparam pix_flags_t FLAGS_RST = '{hs: 1'b1, vs: 1'b1, active: 1'b0, hit: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running pixel/line counters with sync, active-video and the
// once-per-frame attribute load strobe (first pixel of vertical blanking).
module vga_timing_gen
    import vga_sprite_pkg::*;
#(
    parameter int unsigned H_ACT  = H_ACT_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_ACT  = V_ACT_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hs,
    output logic             vs,
    output logic             active,
    output logic             frame_load
);

    localparam int unsigned H_TOTAL = span_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACT, V_FP, V_SYNC, V_BP);

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == CNT_W'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == CNT_W'(V_TOTAL - 1)) vcnt_d = '0;
            else                               vcnt_d = vcnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt       = hcnt_q;
    assign vcnt       = vcnt_q;
    assign hs         = !((hcnt_q >= CNT_W'(H_ACT + H_FP)) && (hcnt_q < CNT_W'(H_ACT + H_FP + H_SYNC)));
    assign vs         = !((vcnt_q >= CNT_W'(V_ACT + V_FP)) && (vcnt_q < CNT_W'(V_ACT + V_FP + V_SYNC)));
    assign active     = (hcnt_q < CNT_W'(H_ACT)) && (vcnt_q < CNT_W'(V_ACT));
    assign frame_load = (hcnt_q == '0) && (vcnt_q == CNT_W'(V_ACT));

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus NUM_SPR-channel rectangle sprite compositor sharing one
// synchronous sprite ROM; emits a palette index aligned with sync/blank.
module vga_sprite_engine
    import vga_sprite_pkg::*;
#(
    parameter int unsigned NUM_SPR    = 4,
    parameter int unsigned ROM_AW     = 17,
    parameter int unsigned H_ACT      = H_ACT_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACT      = V_ACT_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter logic [7:0]  TRANSP_IDX = TRANSP_IDX_DEF,
    parameter logic [7:0]  BG_IDX     = BG_IDX_DEF
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST_n,
    input  logic [NUM_SPR-1:0]        iSPR_EN,
    input  logic [NUM_SPR*X_W-1:0]    iSPR_X,
    input  logic [NUM_SPR*Y_W-1:0]    iSPR_Y,
    input  logic [NUM_SPR*W_W-1:0]    iSPR_W,
    input  logic [NUM_SPR*H_W-1:0]    iSPR_H,
    input  logic [NUM_SPR*ROM_AW-1:0] iSPR_BASE,
    output logic [ROM_AW-1:0]         oROM_ADDR,
    input  logic [7:0]                iROM_DATA,
    output logic                      oHS,
    output logic                      oVS,
    output logic                      oBLANK_n,
    output logic [7:0]                oINDEX,
    output logic                      oFRAME_TICK
);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             hs, vs, active, frame_load;

    vga_timing_gen #(
        .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk        (iVGA_CLK),
        .rst_n      (iRST_n),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hs         (hs),
        .vs         (vs),
        .active     (active),
        .frame_load (frame_load)
    );

    logic [NUM_SPR-1:0]        en_q, en_d;
    logic [NUM_SPR*X_W-1:0]    x_q, x_d;
    logic [NUM_SPR*Y_W-1:0]    y_q, y_d;
    logic [NUM_SPR*W_W-1:0]    w_q, w_d;
    logic [NUM_SPR*H_W-1:0]    h_q, h_d;
    logic [NUM_SPR*ROM_AW-1:0] base_q, base_d;

    always_comb begin
        en_d   = en_q;
        x_d    = x_q;
        y_d    = y_q;
        w_d    = w_q;
        h_d    = h_q;
        base_d = base_q;
        if (frame_load) begin
            en_d   = iSPR_EN;
            x_d    = iSPR_X;
            y_d    = iSPR_Y;
            w_d    = iSPR_W;
            h_d    = iSPR_H;
            base_d = iSPR_BASE;
        end
    end

    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              hit_any;
    logic [CNT_W-1:0]  sx, sy, sw, sh, sx_end, sy_end;
    logic [23:0]       offs;
    int unsigned       ch;

    // Scan from lowest priority upward so the lowest-index hit overwrites last.
    always_comb begin
        hit_any    = 1'b0;
        rom_addr_d = rom_addr_q;
        sx = '0; sy = '0; sw = '0; sh = '0; sx_end = '0; sy_end = '0; offs = '0; ch = 0;
        for (int unsigned k = 0; k < NUM_SPR; k++) begin
            ch     = NUM_SPR - 1 - k;
            sx     = CNT_W'(x_q[ch*X_W +: X_W]);
            sy     = CNT_W'(y_q[ch*Y_W +: Y_W]);
            sw     = CNT_W'(w_q[ch*W_W +: W_W]);
            sh     = CNT_W'(h_q[ch*H_W +: H_W]);
            sx_end = sx + sw;
            sy_end = sy + sh;
            if (en_q[ch] && (hcnt >= sx) && (hcnt < sx_end) && (vcnt >= sy) && (vcnt < sy_end)) begin
                hit_any    = 1'b1;
                offs       = 24'(vcnt - sy) * 24'(sw) + 24'(hcnt - sx);
                rom_addr_d = base_q[ch*ROM_AW +: ROM_AW] + ROM_AW'(offs);
            end
        end
    end

    pix_flags_t s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d = '{hs: hs, vs: vs, active: active, hit: hit_any};
        s2_d = s1_q;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            en_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            base_q     <= '0;
            rom_addr_q <= '0;
            s1_q       <= FLAGS_RST;
            s2_q       <= FLAGS_RST;
        end else begin
            en_q       <= en_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            base_q     <= base_d;
            rom_addr_q <= rom_addr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    // ROM data arrives in the stage-2 cycle, so the final mux stays combinational.
    assign oINDEX      = (s2_q.active && s2_q.hit && (iROM_DATA != TRANSP_IDX)) ? iROM_DATA : BG_IDX;
    assign oROM_ADDR   = rom_addr_q;
    assign oHS         = s2_q.hs;
    assign oVS         = s2_q.vs;
    assign oBLANK_n    = s2_q.active;
    assign oFRAME_TICK = frame_load;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench: reduced raster timing, synchronous ROM model and a per-pixel
// reference of the compositing rules checked every cycle.
module tb_vga_sprite_engine;

    localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
    localparam int VA = 48, VF = 2, VSY = 2, VB = 4;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int NS = 4;
    localparam int AW = 17;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [7:0]  idx;
        logic [16:0] addr;
    } ent_t;

    localparam ent_t RST_E = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, idx: 8'h00, addr: 17'h0};

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NS-1:0]  spr_en;
    logic [NS*11-1:0] spr_x;
    logic [NS*10-1:0] spr_y;
    logic [NS*8-1:0]  spr_w;
    logic [NS*8-1:0]  spr_h;
    logic [NS*AW-1:0] spr_base;
    logic [AW-1:0]  rom_addr;
    logic [7:0]     rom_q;
    logic           hs, vs, blank_n, frame_tick;
    logic [7:0]     index;

    logic [7:0] rom [0:(1<<AW)-1];

    vga_sprite_engine #(
        .NUM_SPR (NS), .ROM_AW (AW),
        .H_ACT (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
        .V_ACT (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
        .TRANSP_IDX (8'hFF), .BG_IDX (8'h00)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iSPR_EN     (spr_en),
        .iSPR_X      (spr_x),
        .iSPR_Y      (spr_y),
        .iSPR_W      (spr_w),
        .iSPR_H      (spr_h),
        .iSPR_BASE   (spr_base),
        .oROM_ADDR   (rom_addr),
        .iROM_DATA   (rom_q),
        .oHS         (hs),
        .oVS         (vs),
        .oBLANK_n    (blank_n),
        .oINDEX      (index),
        .oFRAME_TICK (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    int   checks = 0;
    int   fails  = 0;
    int   k      = 0;
    bit   prev_load = 0;
    ent_t hist [3];
    int   sh_en [NS];
    int   sh_x [NS];
    int   sh_y [NS];
    int   sh_w [NS];
    int   sh_h [NS];
    int   sh_base [NS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic ent_t pixel(input int h, input int v, input logic [16:0] prev_addr);
        ent_t e;
        bit   hit;
        e.hs    = !(h >= HA + HF && h < HA + HF + HSY);
        e.vs    = !(v >= VA + VF && v < VA + VF + VSY);
        e.blank = (h < HA) && (v < VA);
        e.addr  = prev_addr;
        hit     = 0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && sh_en[i] != 0 && h >= sh_x[i] && h < sh_x[i] + sh_w[i]
                     && v >= sh_y[i] && v < sh_y[i] + sh_h[i]) begin
                hit    = 1;
                e.addr = 17'((sh_base[i] + (v - sh_y[i]) * sh_w[i] + (h - sh_x[i])) % (1 << AW));
            end
        end
        e.idx = (e.blank && hit && rom[e.addr] != 8'hFF) ? rom[e.addr] : 8'h00;
        return e;
    endfunction

    function automatic int hpos(input int n); return (n % (HT * VT)) % HT; endfunction
    function automatic int vpos(input int n); return (n % (HT * VT)) / HT; endfunction

    task automatic tick();
        bit ld;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0; sh_base[i] = 0;
            end
            prev_load = 0;
            k         = 0;
            hist[2]   = RST_E;
            hist[1]   = RST_E;
            hist[0]   = pixel(0, 0, 17'h0);
            chk("rst_hs", 32'(hs), 32'(1));
            chk("rst_vs", 32'(vs), 32'(1));
            chk("rst_blank", 32'(blank_n), 32'(0));
            chk("rst_index", 32'(index), 32'(0));
            chk("rst_rom_addr", 32'(rom_addr), 32'(0));
            chk("rst_frame_tick", 32'(frame_tick), 32'(0));
        end else begin
            if (prev_load) begin
                for (int i = 0; i < NS; i++) begin
                    sh_en[i]   = int'(spr_en[i]);
                    sh_x[i]    = int'(spr_x[i*11 +: 11]);
                    sh_y[i]    = int'(spr_y[i*10 +: 10]);
                    sh_w[i]    = int'(spr_w[i*8 +: 8]);
                    sh_h[i]    = int'(spr_h[i*8 +: 8]);
                    sh_base[i] = int'(spr_base[i*AW +: AW]);
                end
            end
            k++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = pixel(hpos(k), vpos(k), hist[1].addr);
            ld      = (hpos(k) == 0) && (vpos(k) == VA);
            chk("hs", 32'(hs), 32'(hist[2].hs));
            chk("vs", 32'(vs), 32'(hist[2].vs));
            chk("blank_n", 32'(blank_n), 32'(hist[2].blank));
            chk("index", 32'(index), 32'(hist[2].idx));
            chk("rom_addr", 32'(rom_addr), 32'(hist[1].addr));
            chk("frame_tick", 32'(frame_tick), 32'(ld));
            prev_load = ld;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int v, input int h);
        bit found = 0;
        for (int i = 0; i <= HT * VT + 2; i++) begin
            if (hpos(k) == h && vpos(k) == v) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        assert (found) else begin
            fails++;
            $error("FAIL run_to: position (%0d,%0d) not reached, observed cycle %0d", h, v, k);
        end
    endtask

    task automatic set_spr(input int i, input bit en, input int x, input int y,
                           input int w, input int h, input int base);
        spr_en[i]             = en;
        spr_x[i*11 +: 11]     = 11'(x);
        spr_y[i*10 +: 10]     = 10'(y);
        spr_w[i*8 +: 8]       = 8'(w);
        spr_h[i*8 +: 8]       = 8'(h);
        spr_base[i*AW +: AW]  = AW'(base);
    endtask

    initial begin
        rst_n    = 1'b0;
        spr_en   = '0;
        spr_x    = '0;
        spr_y    = '0;
        spr_w    = '0;
        spr_h    = '0;
        spr_base = '0;
        for (int a = 0; a < (1 << AW); a++) rom[a] = (a < 4096) ? 8'(a) : 8'($urandom);
        rom[4096 + 3] = 8'hFF;
        rom[4096 + 9] = 8'hFF;

        // Single 4x2 sprite reading ROM[a]=a
        set_spr(0, 1, 10, 5, 4, 2, 0);
        run(4);
        rst_n = 1'b1;
        run_to(VA, 0);
        run(1);
        run_to(VA, 0);

        // Overlapping channels: ch0 wins, its transparent texels show background
        set_spr(0, 1, 10, 10, 8, 8, 4096);
        set_spr(1, 1, 10, 10, 8, 8, 200);
        run(1);
        run_to(VA, 0);

        // ch0 off -> ch1 visible; mid-frame X change must wait for the next load
        set_spr(0, 0, 10, 10, 8, 8, 4096);
        run(1);
        run_to(20, 0);
        set_spr(1, 1, 30, 10, 8, 8, 200);
        set_spr(2, 1, 62, 0, 8, 4, 300);
        run_to(VA, 0);
        run(1);
        run_to(VA, 0);

        // Randomized attribute updates at arbitrary raster positions
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NS; i++)
                set_spr(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, 70)),
                        int'($urandom_range(0, 52)), int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 12)), int'($urandom_range(0, (1 << AW) - 1)));
            run(int'($urandom_range(500, 2500)));
        end

        // Asynchronous reset in the middle of a visible frame
        run_to(VA, 0);
        run(1);
        run_to(30, 5);
        rst_n = 1'b0;
        run(5);
        rst_n = 1'b1;
        run(HT * 12);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
